// File: rtl/nibble_adder_pkg.sv
// ============================================================================
// Module : nibble_adder_pkg
// Brief  : Shared state encoding and nibble width for the serial adder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_adder_pkg;

  localparam int c_nibble_w = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/top_4bit.sv
// ============================================================================
// Module : top_4bit
// Brief  : 4-bit ripple-carry adder; also exposes the carry into bit 3.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_4bit
  import nibble_adder_pkg::*;
(
  input  logic [c_nibble_w-1:0] a,
  input  logic [c_nibble_w-1:0] b,
  input  logic                  cin,
  output logic [c_nibble_w-1:0] sum,
  output logic                  cout,
  output logic                  c_msb
);

  logic [c_nibble_w:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < c_nibble_w; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout  = w_c[c_nibble_w];
  assign c_msb = w_c[c_nibble_w-1];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module : nibble_serial_adder
// Brief  : WIDTH-bit adder computed one nibble per cycle through top_4bit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSTEP = WIDTH / c_nibble_w;
  localparam int IDX_W = $clog2(NSTEP);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NSTEP - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_b;
  logic [WIDTH-1:0]        r_acc;
  logic [WIDTH-1:0]        w_acc_next;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_carry;
  logic [WIDTH-1:0]        r_sum;
  logic                    r_cout;
  logic                    r_ovf;
  logic [c_nibble_w-1:0]   w_a_nib;
  logic [c_nibble_w-1:0]   w_b_nib;
  logic [c_nibble_w-1:0]   w_nib_sum;
  logic                    w_nib_cout;
  logic                    w_nib_cmsb;
  logic                    w_accept;
  logic                    w_last;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_idx == c_last_idx);

  assign w_a_nib = r_a[r_idx*c_nibble_w +: c_nibble_w];
  assign w_b_nib = r_b[r_idx*c_nibble_w +: c_nibble_w];

  top_4bit u_add (
    .a     (w_a_nib),
    .b     (w_b_nib),
    .cin   (r_carry),
    .sum   (w_nib_sum),
    .cout  (w_nib_cout),
    .c_msb (w_nib_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_idx*c_nibble_w +: c_nibble_w] = w_nib_sum;
  end

  // Partial sums build up in r_acc so the visible sum only changes on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_next;
      r_carry <= w_nib_cout;
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_nib_cout;
        r_ovf  <= w_nib_cmsb ^ w_nib_cout;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module : tb_nibble_serial_adder
// Brief  : Directed self-checking bench for nibble_serial_adder (WIDTH=16).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for one edge, then counts edges until out_valid.
  task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vcin, output int lat);
    a = va; b = vb; cin = vcin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    check({name, " in_ready_idle"}, 32'(in_ready), 32'd1);
    launch(v.a, v.b, v.cin, lat);
    check({name, " latency"}, 32'(lat), 32'd4);
    check({name, " sum"}, 32'(sum), 32'(v.sum));
    check({name, " cout"}, 32'(cout), 32'(v.cout));
    check({name, " ovf"}, 32'(ovf), 32'(v.ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] hold_sum;
    logic hold_cout, hold_ovf;
    logic seen;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    // Reset state
    tick();
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: result held for 5 cycles with out_ready low
    launch(16'h1234, 16'h4321, 1'b1, lat);
    check("bp latency", 32'(lat), 32'd4);
    hold_sum = sum; hold_cout = cout; hold_ovf = ovf;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp sum", 32'(sum), 32'(hold_sum));
      check("bp cout", 32'(cout), 32'(hold_cout));
      check("bp ovf", 32'(ovf), 32'(hold_ovf));
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    check("bp sum value", 32'(sum), 32'h5556);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp idle in_ready", 32'(in_ready), 32'd1);
    check("bp idle out_valid", 32'(out_valid), 32'd0);

    // Operands presented during RUN/DONE must be ignored
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    a = 16'hAAAA;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("ign in_ready run", 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    check("ign latency", 32'(lat), 32'd4);
    check("ign in_ready done", 32'(in_ready), 32'd0);
    check("ign sum", 32'(sum), 32'h0100);
    tick();
    check("ign still done", 32'(out_valid), 32'd1);
    check("ign sum hold", 32'(sum), 32'h0100);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("ign consume in_ready", 32'(in_ready), 32'd1);

    // out_ready high throughout: ignored in RUN, consumes one cycle after DONE entry
    launch(16'h0F0F, 16'h0101, 1'b0, lat);
    check("or latency", 32'(lat), 32'd4);
    check("or sum", 32'(sum), 32'h1010);
    tick();
    out_ready = 1'b0;
    check("or consumed", 32'(out_valid), 32'd0);

    // Reset pulse mid-RUN aborts the operation
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("abort no out_valid", 32'(seen), 32'd0);
    check("abort in_ready after", 32'(in_ready), 32'd1);
    run_vec(vecs[2], "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
